memory_arbiter: RTL

//  Shares the single unified Memory between two requesters: the multicycle core
//  (port C) and a debug/loader master (port D). Sits between both masters and Memory.

---
 rtl/memory_arbiter_pkg.sv | 55 +++++
 rtl/memory_arbiter_if.sv | 59 +++++
 rtl/memory_arbiter_arb_select.sv | 47 ++++
 rtl/memory_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared definitions for the memory arbiter slice:
//   - FSM state encodings ARB_IDLE / ARB_ACCESS / ARB_RESP
//   - owner codes OWNER_CORE / OWNER_DEBUG
//   - the latched request record (owner, write, addr, wdata)
//   - pick_req(): selects the granted requester's fields into that record
// No ports (package).
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // FSM state encodings
  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  // Owner codes
  localparam logic OWNER_CORE  = 1'b0;
  localparam logic OWNER_DEBUG = 1'b1;

  // Copy of the winning request, frozen for the whole transaction
  typedef struct packed {
    logic              owner;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic mem_req_t pick_req(
    input logic              who,
    input logic              c_write,
    input logic [ADDR_W-1:0] c_addr,
    input logic [DATA_W-1:0] c_wdata,
    input logic              d_write,
    input logic [ADDR_W-1:0] d_addr,
    input logic [DATA_W-1:0] d_wdata
  );
    mem_req_t r;
    r.owner = who;
    if (who == OWNER_DEBUG) begin
      r.write = d_write;
      r.addr  = d_addr;
      r.wdata = d_wdata;
    end else begin
      r.write = c_write;
      r.addr  = c_addr;
      r.wdata = c_wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the two requester ports (core C, debug D) and the Memory port.
//   c_req/c_write/c_addr/c_wdata  requester -> arbiter   (core)
//   c_rdata/c_ready               arbiter -> requester   (core)
//   d_*                           same set for the debug/loader master
//   mem_addr/mem_wdata/mem_write/mem_read  arbiter -> Memory
//   mem_rdata                              Memory -> arbiter
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + Memory model)
//
// Handshake: a requester raises x_req together with x_write/x_addr/x_wdata and
// keeps them stable until x_ready. x_ready is a single-cycle completion pulse;
// x_rdata is valid while x_ready=1 and holds afterwards. The arbiter samples
// request fields only while idle, so changes after the grant have no effect.
// -----------------------------------------------------------------------------
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic              c_req;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_ready;

  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_write, c_addr, c_wdata,
    output c_rdata, c_ready,
    input  d_req, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output c_req, c_write, c_addr, c_wdata,
    input  c_rdata, c_ready,
    output d_req, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/memory_arbiter_arb_select.sv
// -----------------------------------------------------------------------------
// memory_arbiter_arb_select
// Combinational grant picker used by the arbiter while idle.
//   c_req, d_req  in   pending requests
//   last_owner    in   owner of the previous transaction
//   grant_valid   out  at least one request is pending
//   grant_owner   out  OWNER_CORE / OWNER_DEBUG
// Policy macro: ARB_ROUND_ROBIN_EN
//   defined   : on a tie the port that did not own the last transaction wins
//   undefined : fixed priority, the core wins every tie
// -----------------------------------------------------------------------------
module memory_arbiter_arb_select
  import memory_arbiter_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_valid = c_req | d_req;
    grant_owner = OWNER_CORE;
    if (c_req && d_req) begin
      // alternate on contention so neither side waits more than one transaction
      grant_owner = ~last_owner;
    end else if (d_req) begin
      grant_owner = OWNER_DEBUG;
    end
  end
`else
  // last_owner only matters for the rotating policy
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_valid = c_req | d_req;
    grant_owner = OWNER_CORE;
    if (!c_req && d_req) begin
      grant_owner = OWNER_DEBUG;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one unified Memory between the multicycle core (port C) and a
// debug/loader master (port D). Each access is arbitrated while idle, the
// winner's request is latched and driven to Memory for LATENCY cycles, and the
// read data is returned with a single-cycle ready pulse.
//
// Parameters:
//   LATENCY  Memory access cycles per transaction (1..15)
//   CNT_W    latency counter width (must hold LATENCY)
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   bus        slave modport of memory_arbiter_if (requesters + Memory)
//   busy       out  1 while a transaction is in ACCESS or RESP
//   owner      out  0 = core, 1 = debug; owner of current/last transaction
//   dbg_state  out  FSM state (ARB_IDLE / ARB_ACCESS / ARB_RESP)
// Configuration macro: ARB_ROUND_ROBIN_EN (tie policy, see arb_select).
//
// Timing: request sampled in IDLE at edge 0, ACCESS occupies cycles
// 1..LATENCY, ready pulses in cycle LATENCY+1, IDLE again in LATENCY+2.
// -----------------------------------------------------------------------------
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus,
  output logic             busy,
  output logic             owner,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  mem_req_t          req_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  // last_owner resets to debug so the core wins the first tie; owner_valid
  // keeps the visible owner output at 0 until a transaction has been granted.
  logic              last_owner;
  logic              owner_valid;

  logic              grant_valid;
  logic              grant_owner;
  logic [DATA_W-1:0] resp_data;
  logic              in_access;

  memory_arbiter_arb_select u_arb_select (
    .c_req       (bus.c_req),
    .d_req       (bus.d_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // stores return zero data
  assign resp_data = req_q.write ? '0 : bus.mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      last_owner  <= OWNER_DEBUG;
      owner_valid <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            req_q       <= pick_req(grant_owner,
                                    bus.c_write, bus.c_addr, bus.c_wdata,
                                    bus.d_write, bus.d_addr, bus.d_wdata);
            last_owner  <= grant_owner;
            owner_valid <= 1'b1;
            cnt         <= '0;
            state       <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // only the winner's data register moves; the loser's holds
            if (req_q.owner == OWNER_DEBUG) begin
              d_rdata_q <= resp_data;
            end else begin
              c_rdata_q <= resp_data;
            end
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Memory side is driven only during ACCESS, so an async reset clears it at once
  assign in_access     = (state == ARB_ACCESS);
  assign bus.mem_addr  = in_access ? req_q.addr  : '0;
  assign bus.mem_wdata = in_access ? req_q.wdata : '0;
  assign bus.mem_read  = in_access & ~req_q.write;
  // a store is issued exactly once, on the first ACCESS cycle
  assign bus.mem_write = in_access & req_q.write & (cnt == '0);

  assign bus.c_ready = (state == ARB_RESP) && (req_q.owner == OWNER_CORE);
  assign bus.d_ready = (state == ARB_RESP) && (req_q.owner == OWNER_DEBUG);
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign busy      = (state != ARB_IDLE);
  assign owner     = owner_valid ? last_owner : OWNER_CORE;
  assign dbg_state = state;

endmodule
